// File: rtl/tap_master.sv
// JTAG master: walks the TAP through an IR scan then a DR scan per command and returns captured TDO bits.
// Optional IR cache (skip IR scan on repeated opcode) enabled by defining TAP_MASTER_IR_CACHE_EN.
module tap_master #(
    parameter int CLK_DIV = 4,
    parameter int IR_LEN  = 4,
    parameter int MAX_DR  = 128,
    parameter int LEN_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IR_LEN-1:0] cmd_ir,
    input  logic [LEN_W-1:0]  cmd_dr_len,
    input  logic [MAX_DR-1:0] cmd_dr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [MAX_DR-1:0] rsp_data,
    output logic              busy,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo
);
    typedef enum logic [3:0] {
        INIT, IDLE, IR_HDR, IR_SHIFT, IR_TAIL, DR_HDR, DR_SHIFT, DR_TAIL, RESP
    } state_t;

    localparam int               IDX_W     = (MAX_DR > 1) ? $clog2(MAX_DR) : 1;
    localparam logic [7:0]       DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] CNT_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0] INIT_LAST = LEN_W'(5);
    localparam logic [LEN_W-1:0] IRH_LAST  = LEN_W'(3);
    localparam logic [LEN_W-1:0] DRH_LAST  = LEN_W'(2);
    localparam logic [LEN_W-1:0] IR_LAST   = LEN_W'(IR_LEN - 1);
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_DR);

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d, cnt_nx;
    logic [7:0]          div_q, div_d;
    logic                tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
    logic [IR_LEN-1:0]   ir_q, ir_d;
    logic [LEN_W-1:0]    len_q, len_d, cmd_len_c;
    logic [MAX_DR-1:0]   data_q, data_d, rsp_q, rsp_d;
    logic                cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d, busy_q, busy_d;
    logic                cache_hit;
`ifdef TAP_MASTER_IR_CACHE_EN
    logic [IR_LEN-1:0]   last_ir_q, last_ir_d;
    logic                ir_vld_q, ir_vld_d;
`endif

    assign cmd_len_c = (cmd_dr_len > MAX_LEN) ? MAX_LEN : cmd_dr_len;

    always_comb begin
`ifdef TAP_MASTER_IR_CACHE_EN
        cache_hit = ir_vld_q && (cmd_ir == last_ir_q) && (cmd_len_c != '0);
`else
        cache_hit = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_nx  = cnt_q + CNT_ONE;
        div_d   = div_q;
        tck_d   = tck_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        ir_d    = ir_q;
        len_d   = len_q;
        data_d  = data_q;
        rsp_d   = rsp_q;
`ifdef TAP_MASTER_IR_CACHE_EN
        last_ir_d = last_ir_q;
        ir_vld_d  = ir_vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    ir_d    = cmd_ir;
                    len_d   = cmd_len_c;
                    data_d  = cmd_dr_data;
                    rsp_d   = '0;
                    cnt_d   = '0;
                    tms_d   = 1'b1;
                    tdi_d   = 1'b0;
                    state_d = cache_hit ? DR_HDR : IR_HDR;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    tck_d = ~tck_q;
                    if (!tck_q) begin
                        // Rising TCK: the TAP's TDO for this bit is valid now.
                        if (state_q == DR_SHIFT) rsp_d[cnt_q[IDX_W-1:0]] = tdo;
                    end else begin
                        // Falling TCK ends a bit: set up TMS/TDI for the next one.
                        cnt_d = cnt_nx;
                        case (state_q)
                            INIT: begin
                                if (cnt_q == INIT_LAST) begin
                                    state_d = IDLE;
                                    cnt_d   = '0;
                                    tms_d   = 1'b0;
                                end else begin
                                    tms_d = (cnt_nx != INIT_LAST);
                                end
                            end
                            IR_HDR: begin
                                if (cnt_q == IRH_LAST) begin
                                    state_d = IR_SHIFT;
                                    cnt_d   = '0;
                                    tdi_d   = ir_q[0];
                                    tms_d   = (IR_LAST == '0);
                                end else begin
                                    tms_d = (cnt_nx == CNT_ONE);
                                end
                            end
                            IR_SHIFT: begin
                                // Rotate so the opcode is intact again after the last bit.
                                ir_d = (ir_q >> 1) | (ir_q << (IR_LEN - 1));
                                if (cnt_q == IR_LAST) begin
                                    state_d = IR_TAIL;
                                    cnt_d   = '0;
                                    tms_d   = 1'b1;
                                    tdi_d   = 1'b0;
`ifdef TAP_MASTER_IR_CACHE_EN
                                    last_ir_d = ir_d;
                                    ir_vld_d  = 1'b1;
`endif
                                end else begin
                                    tdi_d = ir_d[0];
                                    tms_d = (cnt_nx == IR_LAST);
                                end
                            end
                            IR_TAIL: begin
                                if (cnt_q == '0 && len_q != '0) begin
                                    state_d = DR_HDR;
                                    cnt_d   = '0;
                                    tms_d   = 1'b1;
                                end else if (cnt_q == '0) begin
                                    tms_d = 1'b0;
                                end else begin
                                    state_d = RESP;
                                    cnt_d   = '0;
                                end
                            end
                            DR_HDR: begin
                                if (cnt_q == DRH_LAST) begin
                                    state_d = DR_SHIFT;
                                    cnt_d   = '0;
                                    tdi_d   = data_q[0];
                                    tms_d   = (len_q == CNT_ONE);
                                end else begin
                                    tms_d = 1'b0;
                                end
                            end
                            DR_SHIFT: begin
                                data_d = data_q >> 1;
                                if (cnt_q == len_q - CNT_ONE) begin
                                    state_d = DR_TAIL;
                                    cnt_d   = '0;
                                    tms_d   = 1'b1;
                                    tdi_d   = 1'b0;
                                end else begin
                                    tdi_d = data_d[0];
                                    tms_d = (cnt_nx == len_q - CNT_ONE);
                                end
                            end
                            DR_TAIL: begin
                                if (cnt_q == '0) begin
                                    tms_d = 1'b0;
                                end else begin
                                    state_d = RESP;
                                    cnt_d   = '0;
                                end
                            end
                            default: state_d = INIT;
                        endcase
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
        endcase
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE) && (state_d != RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            div_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            ir_q        <= '0;
            len_q       <= '0;
            data_q      <= '0;
            rsp_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b1;
`ifdef TAP_MASTER_IR_CACHE_EN
            last_ir_q   <= '0;
            ir_vld_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            ir_q        <= ir_d;
            len_q       <= len_d;
            data_q      <= data_d;
            rsp_q       <= rsp_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
`ifdef TAP_MASTER_IR_CACHE_EN
            last_ir_q   <= last_ir_d;
            ir_vld_q    <= ir_vld_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_q;
    assign busy      = busy_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
endmodule

// File: doc/tap_master.md
Name: tap_master

Overview:
- Clock-domain JTAG master that drives the tck/tms/tdi pins of the on-chip test access port. Sits directly upstream of it, on the tester FPGA and in system-level benches.
- Accepts one command per transaction: IR opcode, DR length and DR data. Walks the TAP through an IR scan, then a DR scan, and returns the captured TDO bits as a response.
- TCK is generated by dividing the system clock.

Parameters:
- CLK_DIV, 4: clk cycles per TCK half-period; legal range 1..255.
- IR_LEN, 4: instruction register length in bits.
- MAX_DR, 128: maximum DR scan length in bits. Sets the cmd_dr_data and rsp_data width.
- LEN_W, 8: width of cmd_dr_len; must satisfy 2^LEN_W > MAX_DR.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  master accepts command
- cmd_ir  in  IR_LEN  opcode to load, shifted LSB first
- cmd_dr_len  in  LEN_W  DR bits to shift, 0..MAX_DR
- cmd_dr_data  in  MAX_DR  DR data, shifted LSB first
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  MAX_DR  captured TDO bits of the DR scan, bit i = i-th shifted bit
- busy  out  1  scan or init sequence in progress
- tck  out  1  JTAG clock, idle low
- tms  out  1  JTAG mode select
- tdi  out  1  JTAG data to TAP
- tdo  in  1  JTAG data from TAP

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=1.
- Reset asserted mid-scan takes effect immediately: all outputs return to reset values and the init sequence restarts on release.
- TCK timing:
  - Each TCK period is 2*CLK_DIV clk cycles: low phase then high phase.
  - tms/tdi update only on the clk edge where tck goes 0.
  - tdo is sampled on the clk edge where tck goes 1.
- States: INIT, IDLE, IR_HDR, IR_SHIFT, IR_TAIL, DR_HDR, DR_SHIFT, DR_TAIL, RESP.
- INIT:
  - After reset, issue 5 TCKs with tms=1, then 1 TCK with tms=0; the TAP ends in Run-Test/Idle.
  - Then go to IDLE.
- IDLE:
  - cmd_ready=1, busy=0, tck held 0, tms=0.
  - On cmd_valid&&cmd_ready: latch cmd_ir, the data and the length, and go to IR_HDR.
  - cmd_dr_len > MAX_DR is clamped to MAX_DR.
- IR_HDR: TMS sequence 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
- IR_SHIFT:
  - IR_LEN TCKs, tdi = cmd_ir bits LSB first.
  - tms=0 on every bit except the last, where tms=1 (Exit1-IR).
  - TDO bits captured here are discarded.
- IR_TAIL:
  - If dr_len > 0: TMS 1,1,0,0 (Update-IR, Select-DR, Capture-DR, Shift-DR), then DR_SHIFT.
  - If dr_len == 0: TMS 1,0 (Update-IR, Run-Test/Idle), then RESP with rsp_data=0.
- DR_SHIFT:
  - dr_len TCKs, LSB first; last bit with tms=1.
  - Captured tdo bit i goes to rsp_data[i]; bits at index dr_len and above read 0.
- DR_TAIL: TMS 1,0 (Update-DR, Run-Test/Idle), then RESP.
- RESP:
  - rsp_valid=1 with rsp_data stable until rsp_ready; tck held 0.
  - On handshake, rsp_valid drops the next cycle and the block returns to IDLE.
  - A new command is not accepted before the response is consumed.
- TCK count per command:
  - IR_LEN + dr_len + 10 when dr_len > 0.
  - IR_LEN + 6 when dr_len == 0.
- busy=1 in every state except IDLE and RESP.
- tdi=0 whenever no shift bit is being driven.

Optional Feature:
- Macro: TAP_MASTER_IR_CACHE_EN.
- When defined:
  - Holds last_ir plus a valid flag, cleared by reset.
  - When cmd_ir == last_ir, the flag is valid and dr_len > 0, the IR scan is skipped: TMS 1,0,0 (Select-DR, Capture-DR, Shift-DR), then DR_SHIFT.
  - The DR scan then costs dr_len + 5 TCKs.
  - last_ir is updated after each IR scan.
- When undefined: every command performs a full IR scan, and no cache registers exist.

Test Plan:
- Reset release with CLK_DIV=2 -> 6 TCKs with TMS 1,1,1,1,1,0, each period 4 clk; then cmd_ready=1, busy=0, tck=0.
- TAP model, cmd_ir=4'h1 (IDCODE), dr_len=32, data=0 -> 46 TCKs; rsp_data[31:0] equals the model IDCODE, with bit0=1; rsp_data[127:32]=0.
- cmd_ir=BYPASS, dr_len=8, data=8'hA5 -> rsp_data[7:0]=8'h4A (one-bit delay, first bit 0); TAP back in Run-Test/Idle.
- dr_len=0, cmd_ir=4'h3 -> 10 TCKs; TAP IR=3 after Update-IR; rsp_data=0.
- rsp_ready held 0 for 50 clk -> rsp_valid and rsp_data stable, cmd_ready=0, no TCK edges. Same run: dr_len=200 is clamped to 128 bits shifted.
- rst_n pulsed in the middle of DR_SHIFT -> tck=0, tms=1 within the reset cycle; INIT sequence reruns. With TAP_MASTER_IR_CACHE_EN, a repeated cmd_ir with dr_len=16 -> 21 TCKs, and the first command after reset still does a full IR scan.
